// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - byte handshake and serial-side status signals of the UART transmit framer
interface uart_tx_framer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, 8 data bits LSB first, optional parity, stop
// One byte can be held behind the frame on the line so consecutive frames run with no idle gap.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic          tx_clk,
    input  logic          reset,
    uart_tx_framer_if.slave tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        serial_q, serial_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        bit_end;
    logic        load;
    logic [7:0]  load_byte;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        load         = 1'b0;
        load_byte    = tx.tx_data;

        accept  = tx.tx_start && !hold_valid_q;
        bit_end = (cnt_q == CNT_MAX);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    // A held byte wins; otherwise a byte arriving right now chains on directly.
                    if (hold_valid_q) begin
                        load         = 1'b1;
                        load_byte    = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept && state_q != IDLE && !(state_q == STOP && bit_end)) begin
            hold_d       = tx.tx_data;
            hold_valid_d = 1'b1;
        end

        if (load) begin
            state_d = START;
            cnt_d   = 16'd0;
            idx_d   = 3'd0;
            shift_d = load_byte;
            par_d   = (PARITY_ODD != 0) ? ~^load_byte : ^load_byte;
        end

        // The line level is registered from the next state so it changes only on clock edges.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            idx_q        <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            serial_q     <= serial_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tx.tx_ready  = !hold_valid_q;
    assign tx.tx_serial = serial_q;
    assign tx.tx_busy   = busy_q;
    assign tx.tx_done   = done_q;

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have one clock, tx_clk, and a synchronous, active-high reset, reset.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 1, giving tx_clk cycles per serial bit (1 = tx_clk is the baud clock); legal range 1..65535.
REQ-003 The block SHALL have parameter PARITY_EN, default 1, where 1 inserts a parity bit after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-005 The block SHALL have port tx_clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port tx_start, input, 1 bit: request to send tx_data.
REQ-008 The block SHALL have port tx_data, input, 8 bits: byte to send, sampled only on acceptance.
REQ-009 The block SHALL have port tx_ready, output, 1 bit: high when a tx_start will be accepted.
REQ-010 The block SHALL have port tx_serial, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: high while a frame is on the line.
REQ-012 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse per completed frame.

Function
REQ-013 Frame format SHALL be: start bit (0), data bits 0..7 LSB first, parity bit if PARITY_EN, stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 The parity bit SHALL be ^tx_data for even parity and ~^tx_data for odd parity, computed from the accepted byte.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-016 A byte SHALL be accepted on any rising edge where tx_start && tx_ready; tx_start with tx_ready low SHALL be ignored without side effect.
REQ-017 The block SHALL contain a 1-deep holding register; tx_ready SHALL equal !hold_valid, so it is high in IDLE and high while sending until a second byte is held.
REQ-018 On acceptance in IDLE, the byte SHALL load directly into the shift register and the FSM SHALL enter START; tx_serial=0 and tx_busy=1 SHALL be driven from the next cycle.
REQ-019 On acceptance while busy, the byte SHALL go into the holding register and hold_valid SHALL be set.
REQ-020 Per-bit timing SHALL use a bit counter 0..CLKS_PER_BIT-1, and a state or bit advance SHALL happen when it reaches CLKS_PER_BIT-1.
REQ-021 A data index 0..7 SHALL select the DATA bit; after index 7, DATA SHALL go to PARITY or STOP.
REQ-022 At the end of STOP with hold_valid=1, the FSM SHALL go directly to START with the held byte; hold_valid SHALL clear and there SHALL be no idle cycle, and tx_busy SHALL stay 1.
REQ-023 At the end of STOP with hold_valid=0, the FSM SHALL go to IDLE; tx_serial=1 and tx_busy=0 SHALL be driven from the next cycle.
REQ-024 tx_done SHALL be high for exactly one cycle, the cycle after the final stop-bit cycle, for every frame, including back-to-back frames.
REQ-025 If a tx_start is accepted in the same cycle that STOP ends with hold empty, the byte SHALL start immediately, treated as back-to-back per REQ-022.
REQ-026 tx_serial SHALL be driven from a register and SHALL be glitch-free.
REQ-027 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL set tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1, FSM=IDLE, all counters=0, and hold_valid=0.
REQ-029 Reset mid-frame SHALL abort the frame with no tx_done, discard the held byte, and return tx_serial high on the next cycle.
REQ-030 reset SHALL take priority over tx_start in the same cycle.

Verification
REQ-031 A bench SHALL check: defaults, tx_data=0x3C, one tx_start pulse -> tx_serial 0,0,0,1,1,1,1,0,0,0,1 (parity 0), tx_busy for 11 cycles, then one tx_done pulse.
REQ-032 A bench SHALL check: defaults, 0x9D -> data 1,0,1,1,1,0,0,1 and parity 1; with PARITY_ODD=1 -> parity 0.
REQ-033 A bench SHALL check: 0x3C accepted, then 0xA5 during the frame -> tx_ready falls, a third tx_start is ignored, and 0xA5 (parity 0) starts the cycle after 0x3C's stop bit with two tx_done pulses in total and no extra byte.
REQ-034 A bench SHALL check: CLKS_PER_BIT=4, PARITY_EN=0, 0x55 -> each bit lasts 4 cycles and the frame lasts 40 cycles.
REQ-035 A bench SHALL check: reset asserted during DATA bit 3 with a byte held -> next cycle tx_serial=1, tx_busy=0, tx_ready=1, no tx_done, and the held byte is never sent.
REQ-036 A bench SHALL check: a loopback of uart_tx_framer into the existing receiver at the same baud clock across all 256 byte values -> the received byte equals the sent byte each time.
